// File: rtl/lm_sm_sequencer.sv
// lm_sm_sequencer: expands an LM/SM instruction into one register transfer per
// selected bit of the imm8 mask. The lowest-numbered register goes first, and
// addresses count up from the base.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   start, is_sm          - instruction valid in RR / SM (1) vs LM (0)
//   reg_list, base_addr   - register mask and starting word address
//   hold                  - downstream stall, freezes the sequencer
//   busy, stall_fetch     - RUN indicator / front-end freeze
//   seq_valid/reg/addr    - one transfer issued this cycle
//   seq_regwrite/memwrite - LM / SM transfer qualifiers
//   seq_pc_write          - LM transfer into R7
//   lm_fwd                - Rs-forwarding enable (low while sequencing)
//   done                  - completion pulse
module lm_sm_sequencer (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        is_sm,
   input  logic [7:0]  reg_list,
   input  logic [15:0] base_addr,
   input  logic        hold,
   output logic        busy,
   output logic        stall_fetch,
   output logic        seq_valid,
   output logic [2:0]  seq_reg,
   output logic [15:0] seq_addr,
   output logic        seq_regwrite,
   output logic        seq_memwrite,
   output logic        seq_pc_write,
   output logic        lm_fwd,
   output logic        done
);

   localparam int unsigned DW = 16;
   localparam int unsigned IW = 3;
   localparam int unsigned LW = 8;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]    state_q, state_d;
   logic [LW-1:0] rem_list, rem_list_d;
   logic [DW-1:0] addr_q, addr_d;
   logic          sm_q, sm_d;

   logic          run;
   logic          advance;
   logic [LW-1:0] rem_clr;
   logic [IW-1:0] low_idx;

   // State registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         rem_list <= '0;
         addr_q   <= '0;
         sm_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         rem_list <= rem_list_d;
         addr_q   <= addr_d;
         sm_q     <= sm_d;
      end
   end

   // Lowest set bit of the remaining mask; the mask with that bit removed
   always_comb begin
      low_idx = '0;
      for (int i = LW - 1; i >= 0; i--) begin
         if (rem_list[i]) low_idx = IW'(i);
      end
      rem_clr = rem_list & (rem_list - LW'(1));
   end

   // Next state and outputs
   always_comb begin
      state_d      = state_q;
      rem_list_d   = rem_list;
      addr_d       = addr_q;
      sm_d         = sm_q;
      run          = (state_q == ST_RUN);
      advance      = run && !hold;
      busy         = run;
      lm_fwd       = !run;
      seq_valid    = advance && (rem_list != '0);
      seq_reg      = low_idx;
      seq_addr     = addr_q;
      seq_regwrite = seq_valid && !sm_q;
      seq_memwrite = seq_valid && sm_q;
      seq_pc_write = seq_valid && !sm_q && (low_idx == IW'(7));
      // At most one bit left means this is the final cycle of the sequence
      done         = advance && (rem_clr == '0);
      stall_fetch  = (!run && start) || (run && !done);

      if (!run) begin
         if (start) begin
            rem_list_d = reg_list;
            addr_d     = base_addr;
            sm_d       = is_sm;
            state_d    = ST_RUN;
         end
      end else if (advance) begin
         rem_list_d = rem_clr;
         if (seq_valid) addr_d = addr_q + DW'(1);
         if (done) state_d = ST_IDLE;
      end
   end

endmodule

// File: doc/lm_sm_sequencer.md
LM_SM_SEQUENCER -- requirements
Module: lm_sm_sequencer

Interface
REQ-001 The block SHALL have the following ports (clock and reset first):
- clk  in  1  single system clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  an LM/SM instruction is valid in the RR stage
- is_sm  in  1  1 = SM (store multiple), 0 = LM (load multiple); sampled with start
- reg_list  in  8  imm8 register mask; bit i selects Ri; sampled with start
- base_addr  in  16  Ra value (already forwarded); sampled with start
- hold  in  1  downstream pipeline stall; freezes the sequencer
- busy  out  1  sequencer is in RUN
- stall_fetch  out  1  freezes the PC, IF/ID and ID/RR registers
- seq_valid  out  1  one register transfer is issued this cycle
- seq_reg  out  3  register index for this transfer (Rd for LM, Rt for SM)
- seq_addr  out  16  word address for this transfer
- seq_regwrite  out  1  LM transfer; feeds EX_Mem_Regwrite downstream
- seq_memwrite  out  1  SM transfer
- seq_pc_write  out  1  LM transfer targeting R7
- lm_fwd  out  1  Rs-forwarding enable for the forwarding unit
- done  out  1  single-cycle completion pulse
REQ-002 The block SHALL have no parameters; data width is fixed at 16 bits, index width at 3 bits.

Function
REQ-003 The block SHALL implement a two-state FSM, IDLE and RUN, with internal registers rem_list[7:0], addr_q[16], and sm_q.
REQ-004 In IDLE, start=1 SHALL load rem_list<=reg_list, addr_q<=base_addr, sm_q<=is_sm and move to RUN on the next edge; hold does not block acceptance.
REQ-005 In RUN, start SHALL be ignored.
REQ-006 In RUN with hold=0 and rem_list!=0, the block SHALL assert seq_valid and drive seq_reg = index of the lowest set bit of rem_list (R0 first).
REQ-007 In each such cycle, seq_addr SHALL equal addr_q; on the edge, that bit SHALL be cleared and addr_q SHALL increment by 1, modulo 2^16 (0xFFFF wraps to 0x0000).
REQ-008 In a seq_valid cycle, the block SHALL drive seq_regwrite=!sm_q and seq_memwrite=sm_q.
REQ-009 seq_pc_write SHALL be 1 only when seq_valid=1, sm_q=0 and seq_reg=3'b111.
REQ-010 When seq_valid=0, seq_regwrite, seq_memwrite and seq_pc_write SHALL be 0; seq_reg and seq_addr are don't-care.
REQ-011 In RUN with hold=1, the block SHALL hold seq_valid=0, rem_list and addr_q unchanged, and done=0.
REQ-012 done SHALL be 1 exactly when state=RUN, hold=0 and rem_list has at most one bit set; the FSM SHALL return to IDLE on that edge.
REQ-013 An empty reg_list SHALL produce one RUN cycle with done=1 and seq_valid=0.
REQ-014 Outputs seq_*, done, busy, stall_fetch and lm_fwd SHALL be combinational from the state registers, start and hold; an issued transfer appears with zero latency in the RUN cycle.
REQ-015 busy SHALL equal (state==RUN).
REQ-016 stall_fetch SHALL equal (state==IDLE && start) || (state==RUN && !done).
REQ-017 lm_fwd SHALL equal !(state==RUN), which blocks Rs forwarding of the block's own writes into the base register during the sequence.
REQ-018 An N-bit mask (N>=1) with no hold SHALL complete in exactly N RUN cycles, with done coincident with the Nth seq_valid.

Reset
REQ-019 reset=1 at a clock edge SHALL force IDLE, rem_list=0, addr_q=0 and sm_q=0, with priority over start and hold.
REQ-020 After reset, outputs SHALL be busy=0, stall_fetch=0 (start=0), seq_valid=0, seq_regwrite=0, seq_memwrite=0, seq_pc_write=0, done=0 and lm_fwd=1.
REQ-021 A reset asserted mid-sequence SHALL abort the sequence; no further seq_valid is issued after the reset edge.

Verification
REQ-022 LM, reg_list=8'b1010_0101, base=0x0040, hold=0 -> four cycles issue (R0,0x0040), (R2,0x0041), (R5,0x0042), (R7,0x0043); seq_regwrite=1 each cycle; seq_pc_write=1 only on the R7 cycle; done with the 4th transfer; lm_fwd=0 for those 4 cycles.
REQ-023 SM, reg_list=8'h01, base=0xFFFF -> one cycle with seq_reg=0, seq_addr=0xFFFF, seq_memwrite=1 and done=1; a second case, reg_list=8'h03, base=0xFFFF -> addresses 0xFFFF then 0x0000.
REQ-024 LM, reg_list=8'h0C, hold=1 in the first RUN cycle -> no transfer in that cycle; next cycles issue R2 then R3 with unchanged address order; stall_fetch stays 1 until done.
REQ-025 reg_list=8'h00 -> exactly one RUN cycle with done=1, seq_valid=0, stall_fetch=1 only in the start cycle.
REQ-026 reset asserted after the 2nd transfer of reg_list=8'hFF -> IDLE next cycle, no further seq_valid, lm_fwd=1; start pulses issued during RUN are ignored.
